// File: rtl/square_voice_pkg.sv
// Shared constants and types for the square-wave voice scheduler.
package square_voice_pkg;

  // Default widths; modules expose these as overridable parameters.
  localparam int DEF_VOICES = 4;
  localparam int DEF_NOTE_W = 7;
  localparam int DEF_DIV_W  = 16;
  localparam int DEF_AGE_W  = 8;

  // Saturation point of the per-voice age counter at the default width.
  localparam logic [DEF_AGE_W-1:0] AGE_MAX = {DEF_AGE_W{1'b1}};

  // Scheduler FSM encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  // One voice worth of state at the default widths.
  typedef struct packed {
    logic                  ena;
    logic [DEF_NOTE_W-1:0] note;
    logic [DEF_DIV_W-1:0]  div;
    logic [DEF_AGE_W-1:0]  age;
  } voice_rec_t;

endpackage

// File: rtl/square_voice_slot.sv
// One oscillator voice record: enable, note, divisor and saturating age.
module square_voice_slot
  import square_voice_pkg::*;
#(
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int AGE_W  = DEF_AGE_W
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              clr_i,      // panic: drop enable and age
  input  logic              load_i,     // note-on lands here
  input  logic              off_i,      // note-off matched here
  input  logic              age_inc_i,  // another voice was loaded
  input  logic [NOTE_W-1:0] note_i,
  input  logic [DIV_W-1:0]  div_i,
  output logic              ena_o,
  output logic [NOTE_W-1:0] note_o,
  output logic [DIV_W-1:0]  div_o,
  output logic [AGE_W-1:0]  age_o
);

  localparam logic [AGE_W-1:0] AGE_TOP = {AGE_W{1'b1}};

  logic              ena_q, ena_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [AGE_W-1:0]  age_q, age_d;

  // Next-state: clear beats load beats off beats aging; note/div survive off.
  always_comb begin
    ena_d  = ena_q;
    note_d = note_q;
    div_d  = div_q;
    age_d  = age_q;
    if (clr_i) begin
      ena_d = 1'b0;
      age_d = '0;
    end else if (load_i) begin
      ena_d  = 1'b1;
      note_d = note_i;
      div_d  = div_i;
      age_d  = '0;
    end else if (off_i) begin
      ena_d = 1'b0;
      age_d = '0;
    end else if (age_inc_i && ena_q && (age_q != AGE_TOP)) begin
      age_d = age_q + 1'b1;
    end
  end

  // Voice record register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      ena_q  <= 1'b0;
      note_q <= '0;
      div_q  <= '0;
      age_q  <= '0;
    end else begin
      ena_q  <= ena_d;
      note_q <= note_d;
      div_q  <= div_d;
      age_q  <= age_d;
    end
  end

  assign ena_o  = ena_q;
  assign note_o = note_q;
  assign div_o  = div_q;
  assign age_o  = age_q;

endmodule

// File: rtl/square_voice_scheduler.sv
// Note-on/off allocator over VOICES square voices. One request in flight:
// scan one voice per cycle, then a single commit cycle.
module square_voice_scheduler
  import square_voice_pkg::*;
#(
  parameter int VOICES = DEF_VOICES,
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int DIV_W  = DEF_DIV_W,
  parameter int AGE_W  = DEF_AGE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_on,
  input  logic [NOTE_W-1:0]        req_note,
  input  logic [DIV_W-1:0]         req_div,
  input  logic                     all_off,
  output logic [VOICES-1:0]        voice_ena,
  output logic [VOICES*DIV_W-1:0]  voice_div,
  output logic [VOICES*NOTE_W-1:0] voice_note,
  output logic                     steal
);

  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VOICES - 1);

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Latched request
  logic              on_q, on_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DIV_W-1:0]  div_q, div_d;

  // Scan results
  logic              match_vld_q, match_vld_d;
  logic [IDX_W-1:0]  match_idx_q, match_idx_d;
  logic              free_vld_q, free_vld_d;
  logic [IDX_W-1:0]  free_idx_q, free_idx_d;
  logic              old_vld_q, old_vld_d;
  logic [IDX_W-1:0]  old_idx_q, old_idx_d;
  logic [AGE_W-1:0]  old_age_q, old_age_d;

  logic              steal_q, steal_d;

  logic [AGE_W-1:0]  voice_age [VOICES];
  logic              cur_ena;
  logic [NOTE_W-1:0] cur_note;
  logic [AGE_W-1:0]  cur_age;

  logic              apply_go;
  logic [IDX_W-1:0]  tgt_idx;
  logic [VOICES-1:0] load_v, off_v, inc_v;

  assign req_ready = (state_q == ST_IDLE) & ~rst & ~all_off;

  // Voice under inspection this SCAN cycle (committed state only).
  assign cur_ena  = voice_ena[idx_q];
  assign cur_note = voice_note[idx_q*NOTE_W +: NOTE_W];
  assign cur_age  = voice_age[idx_q];

  // FSM, request latch and scan bookkeeping.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    on_d        = on_q;
    note_d      = note_q;
    div_d       = div_q;
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d     = ST_SCAN;
          idx_d       = '0;
          on_d        = req_on;
          note_d      = req_note;
          // A zero divisor would stall the generator; clamp to 1.
          div_d       = (req_div == '0) ? DIV_W'(1) : req_div;
          match_vld_d = 1'b0;
          free_vld_d  = 1'b0;
          old_vld_d   = 1'b0;
          match_idx_d = '0;
          free_idx_d  = '0;
          old_idx_d   = '0;
          old_age_d   = '0;
        end
      end
      ST_SCAN: begin
        if (cur_ena && (cur_note == note_q) && !match_vld_q) begin
          match_vld_d = 1'b1;
          match_idx_d = idx_q;
        end
        if (!cur_ena && !free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
        // Strict compare keeps the lowest index on equal ages.
        if (cur_ena && (!old_vld_q || (cur_age > old_age_q))) begin
          old_vld_d = 1'b1;
          old_idx_d = idx_q;
          old_age_d = cur_age;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = ST_APPLY;
      end
      ST_APPLY: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (all_off) state_d = ST_IDLE;
  end

  // Commit decision: retrigger, else free slot, else steal the oldest.
  always_comb begin
    apply_go = (state_q == ST_APPLY) && !all_off;
    if (match_vld_q)     tgt_idx = match_idx_q;
    else if (free_vld_q) tgt_idx = free_idx_q;
    else                 tgt_idx = old_idx_q;
    steal_d = apply_go && on_q && !match_vld_q && !free_vld_q && old_vld_q;
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      on_q        <= 1'b0;
      note_q      <= '0;
      div_q       <= '0;
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      steal_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      on_q        <= on_d;
      note_q      <= note_d;
      div_q       <= div_d;
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      steal_q     <= steal_d;
    end
  end

  assign steal = steal_q;

  for (genvar g = 0; g < VOICES; g++) begin : g_slot
    assign load_v[g] = apply_go && on_q && (tgt_idx == IDX_W'(g));
    assign inc_v[g]  = apply_go && on_q && (tgt_idx != IDX_W'(g));
    assign off_v[g]  = apply_go && !on_q && match_vld_q && (match_idx_q == IDX_W'(g));

    square_voice_slot #(
      .NOTE_W (NOTE_W),
      .DIV_W  (DIV_W),
      .AGE_W  (AGE_W)
    ) u_slot (
      .clk       (clk),
      .rst_i     (rst),
      .clr_i     (all_off),
      .load_i    (load_v[g]),
      .off_i     (off_v[g]),
      .age_inc_i (inc_v[g]),
      .note_i    (note_q),
      .div_i     (div_q),
      .ena_o     (voice_ena[g]),
      .note_o    (voice_note[g*NOTE_W +: NOTE_W]),
      .div_o     (voice_div[g*DIV_W +: DIV_W]),
      .age_o     (voice_age[g])
    );
  end

endmodule
